uart_rx_deframer: RTL

- UART receiver that consumes the board serial input fpag_uart_rx and turns the 8N1 bit stream into bytes.
- Output is a one-entry valid/ready byte buffer for downstream command/echo logic.
- Flags framing errors and overruns.
- Sits immediately downstream of the FPGA UART pin, in parallel with the existing pin-level loopback path.

---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx_deframer.sv | 87 ++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte valid/ready channel plus status pulses.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;
  modport master (output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy, input rx_ready);
  modport slave  (input rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy, output rx_ready);
endinterface

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 UART receiver with a one-entry valid/ready byte buffer.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic      clk,
  input logic      rst,
  input logic      fpag_uart_rx,
  uart_rx_if.master rx
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  logic [1:0]  sync_q;
  logic        rxs;
  logic [2:0]  state;
  logic [15:0] cnt;
  logic [2:0]  bidx;
  logic [7:0]  sh;
  logic [15:0] limit;
  logic        hit;
  logic        done;
  logic        ferr;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;
  logic        ovr_q;
  assign rxs = sync_q[1];
  always_comb begin
    limit = state == START ? HALF : FULL;
    hit   = cnt == limit;
    done  = state == STOP && hit && rxs;
    ferr  = state == STOP && hit && !rxs;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], fpag_uart_rx};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      sh    <= '0;
    end else begin
      cnt <= (state == IDLE || state == BRK || hit) ? 16'd0 : cnt + 16'd1;
      case (state)
        IDLE:  if (!rxs) state <= START;
        START: if (hit) begin
          state <= rxs ? IDLE : DATA;
          bidx  <= '0;
        end
        DATA:  if (hit) begin
          sh    <= {rxs, sh[7:1]};
          bidx  <= bidx + 3'd1;
          state <= bidx == 3'd7 ? STOP : DATA;
        end
        // Return to IDLE on the stop sample so a back-to-back start bit is caught
        STOP:  if (hit) state <= rxs ? IDLE : BRK;
        BRK:   if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= ferr;
      ovr_q  <= done && valid_q && !rx.rx_ready;
      if (done && (!valid_q || rx.rx_ready)) begin
        data_q  <= sh;
        valid_q <= 1'b1;
      end else if (valid_q && rx.rx_ready) valid_q <= 1'b0;
    end
  end
  assign rx.rx_data      = data_q;
  assign rx.rx_valid     = valid_q;
  assign rx.rx_frame_err = ferr_q;
  assign rx.rx_overrun   = ovr_q;
  assign rx.rx_busy      = state != IDLE;
endmodule
